imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width for requester and memory ports.
REQ-002 Parameter DATA_W, default 32, data width for requester and memory ports.
REQ-003 Parameter STARVE_MAX, default 4, legal range 1..15, consecutive loader-denied cycles before the loader is forced a grant.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clka  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  f_rdata valid.
- f_rdata  out  DATA_W  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) or read (0).
- l_addr  in  ADDR_W  loader word address.
- l_wdata  in  DATA_W  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  l_rdata valid.
- l_rdata  out  DATA_W  loader read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after the address is sampled.

Function
REQ-005 The block SHALL arbitrate in every cycle and SHALL grant at most one requester per cycle; f_gnt and l_gnt are combinational from the requests and the registered state, and are never both 1.
REQ-006 The default priority SHALL be fetch: if f_req=1, f_gnt=1, unless the forced-loader condition of REQ-008 holds.
REQ-007 The block SHALL keep a 4-bit starve counter: it increments, saturating at STARVE_MAX, on each cycle with l_req=1 and l_gnt=0, and clears on any cycle with l_gnt=1 or l_req=0.
REQ-008 The block SHALL assert l_gnt when l_req=1 and either f_req=0 or starve==STARVE_MAX.
REQ-009 In a granted cycle, mem_addr, mem_we and mem_wdata SHALL equal the granted requester's address, write enable and write data; the fetch requester always drives we=0.
REQ-010 In an idle cycle, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL hold their last granted values.
REQ-011 The block SHALL have two states: IDLE (no read in flight) and RD (read response due this cycle); a read grant enters RD the next cycle, and the source of that read (F or L) is recorded in a register.
REQ-012 In RD, the block SHALL assert exactly one rvalid for one cycle, for the recorded source, with that source's rdata equal to mem_rdata.
REQ-013 RD SHALL be followed by RD if a read is granted in the RD cycle; otherwise it returns to IDLE. Back-to-back reads achieve one read per cycle.
REQ-014 A loader write grant SHALL produce no rvalid.
REQ-015 Outside its valid cycle, each rdata output SHALL drive 0.
REQ-016 Requesters SHALL hold req, addr and data stable until their gnt; the block does not queue requests.
REQ-017 Simultaneous f_req and l_req with starve<STARVE_MAX SHALL grant fetch. At starve==STARVE_MAX, the loader is granted and starve clears in the next cycle.

Reset
REQ-018 While rst=1, all outputs SHALL be 0, state=IDLE and starve=0, asynchronously.
REQ-019 A read in flight when rst asserts SHALL be discarded, with no rvalid after reset release.
REQ-020 The first arbitration SHALL take place on the first rising clka edge with rst=0.

Verification
REQ-021 Fetch-only: f_req=1 with addresses 0,1,2 over 3 cycles against an array model -> f_gnt=1 on each cycle, and f_rvalid=1 one cycle after each grant with f_rdata = model[0], [1], [2].
REQ-022 Loader write then read: l_we=1, l_addr=5, l_wdata=32'h1234 -> mem_we=1 for one cycle and no l_rvalid. Then l_we=0, l_addr=5 -> l_rvalid one cycle later with l_rdata=32'h1234.
REQ-023 Contention, STARVE_MAX=4: f_req and l_req held at 1 -> f_gnt on cycles 0-3, l_gnt on cycle 4, f_gnt on cycles 5-8, and the pattern repeats.
REQ-024 Mixed back-to-back: fetch read, then loader read, then fetch read on consecutive cycles -> rvalid sequence F, L, F with each rvalid one cycle after its grant, and never both rvalids high.
REQ-025 Reset mid-read: rst asserted in the cycle after a fetch grant -> f_rvalid=0 immediately and after release, and starve=0.
REQ-026 Assertions on every cycle: never both gnts high; mem_we high only with l_gnt and l_we; and rvalids one-hot or zero.

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch has priority, loader is forced a grant
// after STARVE_MAX denied cycles; single-cycle read latency is tracked by a two-state FSM.
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, RD} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t            state;
    state_t            state_nx;
    logic              src_l;
    logic              src_l_nx;
    logic [3:0]        starve;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              force_l;
    logic              rd_gnt;

    always_comb begin
        force_l = l_req && (!f_req || starve == SMAX);
        l_gnt   = !rst && force_l;
        f_gnt   = !rst && f_req && !force_l;
        rd_gnt  = f_gnt || (l_gnt && !l_we);
    end

    // Idle cycles replay the last granted address/data
    always_comb begin
        mem_we    = l_gnt && l_we;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        unique case (1'b1)
            f_gnt: mem_addr = f_addr;
            l_gnt: begin
                mem_addr  = l_addr;
                mem_wdata = l_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            starve  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (l_req && !l_gnt) begin
                if (starve != SMAX)
                    starve <= starve + 4'd1;
            end else begin
                starve <= '0;
            end
            if (f_gnt)
                addr_q <= f_addr;
            if (l_gnt) begin
                addr_q  <= l_addr;
                wdata_q <= l_wdata;
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            src_l <= 1'b0;
        end else begin
            state <= state_nx;
            src_l <= src_l_nx;
        end
    end

    always_comb begin
        state_nx = rd_gnt ? RD : IDLE;
        src_l_nx = rd_gnt ? l_gnt : src_l;
    end

    always_comb begin
        f_rvalid = (state == RD) && !src_l;
        l_rvalid = (state == RD) && src_l;
        f_rdata  = f_rvalid ? mem_rdata : '0;
        l_rdata  = l_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised and directed bench for imem_arbiter with a queue-based scoreboard
// and an arbitration reference model.
module tb_imem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clka = 1'b0;
    logic          rst  = 1'b1;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_req = 1'b0;
    logic          l_we = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          l_gnt;
    logic          l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    imem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clka(clka),
        .rst(rst),
        .f_req(f_req),
        .f_addr(f_addr),
        .f_gnt(f_gnt),
        .f_rvalid(f_rvalid),
        .f_rdata(f_rdata),
        .l_req(l_req),
        .l_we(l_we),
        .l_addr(l_addr),
        .l_wdata(l_wdata),
        .l_gnt(l_gnt),
        .l_rvalid(l_rvalid),
        .l_rdata(l_rdata),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clka = ~clka;

    function automatic logic [DW-1:0] seed(int i);
        return DW'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Synchronous memory with one-cycle read latency
    logic [DW-1:0] tbmem [256];
    bit            mem_ready = 1'b0;
    always @(posedge clka) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++)
                tbmem[i] <= seed(i);
            mem_ready <= 1'b1;
        end else begin
            if (mem_we)
                tbmem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= tbmem[mem_addr[7:0]];
        end
    end

    typedef struct {
        bit            src;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] refmem [256];
    int            starve_m = 0;
    logic [AW-1:0] last_addr_m = '0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            g_f;
    bit            g_l;
    logic          dut_lg;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration for the current cycle
    task automatic check_arb();
        bit el;
        bit ef;
        el = l_req && (!f_req || starve_m == SMAX);
        ef = f_req && !el;
        dut_lg = l_gnt;
        chk("f_gnt", f_gnt, ef);
        chk("l_gnt", l_gnt, el);
        chk("mem_we", mem_we, el && l_we);
        if (ef) begin
            chk("mem_addr_f", mem_addr, f_addr);
            q.push_back('{1'b0, refmem[f_addr[7:0]], cyc + 1});
            last_addr_m = f_addr;
        end else if (el) begin
            chk("mem_addr_l", mem_addr, l_addr);
            if (l_we) begin
                chk("mem_wdata", mem_wdata, l_wdata);
                refmem[l_addr[7:0]] = l_wdata;
            end else begin
                q.push_back('{1'b1, refmem[l_addr[7:0]], cyc + 1});
            end
            last_addr_m = l_addr;
        end else begin
            chk("mem_addr_idle", mem_addr, last_addr_m);
        end
        if (l_req && !el)
            starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
        else
            starve_m = 0;
        g_f = ef;
        g_l = el;
    endtask

    task automatic step();
        @(negedge clka);
        check_arb();
        @(posedge clka);
        #1;
    endtask

    always @(negedge clka) begin
        if (!rst) begin
            checks++;
            if ((f_gnt && l_gnt) || (f_rvalid && l_rvalid) ||
                (mem_we && !(l_gnt && l_we))) begin
                errors++;
                $display("FAIL invariant: gnt=%b%b rv=%b%b we=%b", f_gnt, l_gnt,
                         f_rvalid, l_rvalid, mem_we);
            end
            if (f_rvalid || l_rvalid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: f=%b l=%b", f_rvalid, l_rvalid);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rv_due", 64'(cyc), 64'(e.due));
                    chk("rv_src", l_rvalid, e.src);
                    chk("rdata", e.src ? l_rdata : f_rdata, e.data);
                    chk("rdata_other", e.src ? f_rdata : l_rdata, 0);
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_rvalid: due %0d src %0d", e.due, e.src);
            end
        end
    end

    task automatic idle(int n);
        f_req = 1'b0;
        l_req = 1'b0;
        for (int i = 0; i < n; i++)
            step();
    endtask

    initial begin
        bit fp;
        bit lp;
        for (int i = 0; i < 256; i++)
            refmem[i] = seed(i);

        // Reset: outputs held low even with requests asserted
        f_req = 1'b1;
        l_req = 1'b1;
        l_we  = 1'b1;
        repeat (3) @(posedge clka);
        @(negedge clka);
        chk("rst_f_gnt", f_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid", {f_rvalid, l_rvalid}, 0);
        f_req = 1'b0;
        l_req = 1'b0;
        @(posedge clka);
        #1;
        rst = 1'b0;

        // Fetch-only, addresses 0..2
        f_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_addr = AW'(i);
            step();
        end
        idle(2);

        // Loader write then read back
        l_req   = 1'b1;
        l_we    = 1'b1;
        l_addr  = 5;
        l_wdata = 32'h1234;
        step();
        l_we = 1'b0;
        step();
        idle(2);
        chk("l_write_read", refmem[5], 32'h1234);

        // Contention: loader wins every fifth cycle
        f_req  = 1'b1;
        f_addr = 20;
        l_req  = 1'b1;
        l_we   = 1'b0;
        l_addr = 21;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("contention_l_gnt", dut_lg, (i % 5) == 4);
        end
        idle(2);

        // Mixed back-to-back F, L, F
        f_req  = 1'b1;
        f_addr = 10;
        step();
        f_req  = 1'b0;
        l_req  = 1'b1;
        l_we   = 1'b0;
        l_addr = 11;
        step();
        l_req  = 1'b0;
        f_req  = 1'b1;
        f_addr = 12;
        step();
        idle(2);

        // Randomised traffic honouring hold-until-grant
        fp = 1'b0;
        lp = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!fp && $urandom_range(0, 9) < 6) begin
                fp     = 1'b1;
                f_addr = AW'($urandom_range(0, 255));
            end
            if (!lp && $urandom_range(0, 9) < 5) begin
                lp      = 1'b1;
                l_we    = 1'($urandom_range(0, 1));
                l_addr  = AW'($urandom_range(0, 255));
                l_wdata = $urandom;
            end
            f_req = fp;
            l_req = lp;
            step();
            if (g_f) fp = 1'b0;
            if (g_l) lp = 1'b0;
        end
        idle(3);

        // Reset with a read in flight and the loader starving
        f_req  = 1'b1;
        f_addr = 7;
        l_req  = 1'b1;
        l_we   = 1'b0;
        l_addr = 8;
        step();
        step();
        rst = 1'b1;
        #1;
        q.delete();
        starve_m    = 0;
        last_addr_m = '0;
        chk("rstmid_f_rvalid", f_rvalid, 0);
        chk("rstmid_f_rdata", f_rdata, 0);
        chk("rstmid_f_gnt", f_gnt, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_starve", dut.starve, 0);
        f_req = 1'b0;
        l_req = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        rst = 1'b0;
        idle(4);

        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding", q.size());
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
